// File: rtl/seq_1010_tx.sv
// seq_1010_tx
// Serial frame transmitter feeding the "1010" sequence detector.
// Each frame has three parts, one bit per clk on a registered serial line:
//   - the sync word 1010,
//   - a DATA_W-bit payload, MSB first,
//   - GAP_CYCLES forced zeros.
//
// Ports:
//   clk        clock, rising edge
//   areset     asynchronous active-high reset
//   data_in    payload word, sampled only on an accepting edge
//   valid_in   data_in is valid
//   ready_out  block can accept a word (idle and not in reset)
//   out        registered serial bit
//   busy       registered, high while a frame is in flight
//   done       registered one-cycle pulse while the payload LSB is on out
module seq_1010_tx #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              out,
    output logic              busy,
    output logic              done
);

    // The counter must hold max(4, DATA_W, GAP_CYCLES)-1.
    // That maximum is always at least 4, so the counter is at least 2 bits wide.
    localparam int M1    = (DATA_W > 4) ? DATA_W : 4;
    localparam int M2    = (GAP_CYCLES > M1) ? GAP_CYCLES : M1;
    localparam int CNT_W = $clog2(M2);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              out_reg, out_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [DATA_W-1:0] shift_left;

    // Shift register contents after one left shift, with zero fill.
    assign shift_left[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < DATA_W; gi++) begin : g_shift
            assign shift_left[gi] = shift_reg[gi-1];
        end
    endgenerate

    // Every *_next value describes the cycle after the coming edge.
    // That lets out, busy and done come straight from flops and still line up
    // with the state they belong to.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        out_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                // Accepting needs ready_out as well, but ready_out differs from
                // the IDLE state only while areset is high. The flops are held
                // cleared during that time, so valid_in alone is enough here.
                if (valid_in) begin
                    state_next = SYNC;
                    cnt_next   = '0;
                    shift_next = data_in;
                    out_next   = 1'b1;
                end
            end
            SYNC: begin
                if (cnt_reg == SYNC_LAST) begin
                    state_next = DATA;
                    cnt_next   = '0;
                    out_next   = shift_reg[DATA_W-1];
                    shift_next = shift_left;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    // Sync bit k is 1 when k is even. The next bit is k = cnt+1,
                    // so it is 1 exactly when the current count is odd.
                    out_next = cnt_reg[0];
                end
            end
            DATA: begin
                if (cnt_reg == DATA_LAST) begin
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    out_next   = shift_reg[DATA_W-1];
                    shift_next = shift_left;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                shift_next = '0;
            end
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == DATA) && (cnt_next == DATA_LAST);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign ready_out = (state_reg == IDLE) && !areset;
    assign out       = out_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_seq_1010_tx.sv
// tb_seq_1010_tx
// Self-checking bench for seq_1010_tx. It drives two instances from the same
// stimulus:
//   - u_dut0 with DATA_W=8, GAP_CYCLES=2,
//   - u_dut1 with DATA_W=1, GAP_CYCLES=0.
// The reference model keeps one queue per instance. Each queue holds the
// expected {done,out} pairs still to appear, and the front entry is the pair
// on the line right now. A word is accepted only when the queue is empty;
// the whole frame is then built from the framing rule.
module tb_seq_1010_tx;

    typedef logic [1:0] bq_t[$];

    logic       clk      = 1'b0;
    logic       areset   = 1'b1;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;

    logic ready0, out0, busy0, done0;
    logic ready1, out1, busy1, done1;

    int n_cmp = 0;
    int n_bad = 0;

    bq_t q0;
    bq_t q1;

    always #5 clk = ~clk;

    seq_1010_tx #(.DATA_W(8), .GAP_CYCLES(2)) u_dut0 (
        .clk       (clk),
        .areset    (areset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready0),
        .out       (out0),
        .busy      (busy0),
        .done      (done0)
    );

    seq_1010_tx #(.DATA_W(1), .GAP_CYCLES(0)) u_dut1 (
        .clk       (clk),
        .areset    (areset),
        .data_in   (data_in[0:0]),
        .valid_in  (valid_in),
        .ready_out (ready1),
        .out       (out1),
        .busy      (busy1),
        .done      (done1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One frame as {done,bit} pairs: the sync word, the payload MSB first
    // (done set on its last bit), then gap zeros.
    function automatic bq_t make_frame(input int dw, input int gap, input logic [31:0] w);
        bq_t r;
        r = {};
        for (int k = 0; k < 4; k++)
            r.push_back({1'b0, (k % 2 == 0) ? 1'b1 : 1'b0});
        for (int k = 0; k < dw; k++)
            r.push_back({(k == dw - 1) ? 1'b1 : 1'b0, w[dw-1-k]});
        for (int k = 0; k < gap; k++)
            r.push_back(2'b00);
        return r;
    endfunction

    // Compare all outputs of both instances against the model's current view.
    task automatic check_outputs(input string tag);
        logic [1:0] e0, e1;
        e0 = (q0.size() > 0) ? q0[0] : 2'b00;
        e1 = (q1.size() > 0) ? q1[0] : 2'b00;
        check_val({tag, "_out0"},   32'(out0),   32'(e0[0]));
        check_val({tag, "_done0"},  32'(done0),  32'(e0[1]));
        check_val({tag, "_busy0"},  32'(busy0),  32'(q0.size() > 0));
        check_val({tag, "_ready0"}, 32'(ready0), 32'((q0.size() == 0) && !areset));
        check_val({tag, "_out1"},   32'(out1),   32'(e1[0]));
        check_val({tag, "_done1"},  32'(done1),  32'(e1[1]));
        check_val({tag, "_busy1"},  32'(busy1),  32'(q1.size() > 0));
        check_val({tag, "_ready1"}, 32'(ready1), 32'((q1.size() == 0) && !areset));
    endtask

    // One clock:
    //   - advance the model at the rising edge,
    //   - check outputs on the falling edge.
    // After this returns, the caller drives new inputs.
    task automatic do_cycle(input string tag);
        bit acc0, acc1;
        @(posedge clk);
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (areset) begin
            q0 = {};
            q1 = {};
        end else begin
            if (valid_in && q0.size() == 0) begin
                q0   = make_frame(8, 2, 32'(data_in));
                acc0 = 1'b1;
            end else if (q0.size() > 0) begin
                void'(q0.pop_front());
            end
            if (valid_in && q1.size() == 0) begin
                q1   = make_frame(1, 0, 32'(data_in[0]));
                acc1 = 1'b1;
            end else if (q1.size() > 0) begin
                void'(q1.pop_front());
            end
        end
        if (acc0) $display("[%0t] %s: dut0 accepts word %02h", $time, tag, data_in);
        if (acc1) $display("[%0t] %s: dut1 accepts bit %0b", $time, tag, data_in[0]);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        // Reset held from time 0, checked for a few cycles, then released mid-cycle.
        for (int i = 0; i < 3; i++) do_cycle("reset");
        #2 areset = 1'b0;
        for (int i = 0; i < 10; i++) do_cycle("idle");

        // Single frame carrying A5.
        data_in  = 8'hA5;
        valid_in = 1'b1;
        do_cycle("a5");
        valid_in = 1'b0;
        data_in  = 8'h00;
        for (int i = 0; i < 20; i++) do_cycle("a5");

        // Back-to-back with valid_in held high. Switch to 00 after the first accept.
        data_in  = 8'hFF;
        valid_in = 1'b1;
        do_cycle("b2b");
        data_in = 8'h00;
        for (int i = 0; i < 34; i++) do_cycle("b2b");
        valid_in = 1'b0;
        for (int i = 0; i < 16; i++) do_cycle("b2b");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = 8'($urandom);
            do_cycle("rand");
        end
        valid_in = 1'b0;
        for (int i = 0; i < 16; i++) do_cycle("drain");

        // Mid-frame reset during payload bits, then a clean frame.
        data_in  = 8'h3C;
        valid_in = 1'b1;
        do_cycle("mid");
        valid_in = 1'b0;
        for (int i = 0; i < 7; i++) do_cycle("mid");
        #2 areset = 1'b1;
        #1;
        q0 = {};
        q1 = {};
        check_val("async_out0",   32'(out0),   32'd0);
        check_val("async_busy0",  32'(busy0),  32'd0);
        check_val("async_done0",  32'(done0),  32'd0);
        check_val("async_ready0", 32'(ready0), 32'd0);
        for (int i = 0; i < 2; i++) do_cycle("inrst");
        #2 areset = 1'b0;
        for (int i = 0; i < 3; i++) do_cycle("post");
        data_in  = 8'h81;
        valid_in = 1'b1;
        do_cycle("x81");
        valid_in = 1'b0;
        for (int i = 0; i < 20; i++) do_cycle("x81");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_1010_tx.md
# seq_1010_tx

Serial frame transmitter that produces the bit stream consumed by the team's Mealy "1010" sequence detector. Each frame is the 4-bit sync word 1010, followed by a DATA_W-bit payload sent MSB first, followed by GAP_CYCLES idle zeros. The block accepts one payload word at a time through a valid/ready handshake. It drives a single registered serial line, one bit per clk.

## Interface
- DATA_W, 8, payload width in bits; legal range 1..32.
- GAP_CYCLES, 2, number of forced-0 bits after each payload; legal range 0..15.

- clk  input  1  clock; all state changes on the rising edge.
- areset  input  1  reset, asynchronous, active-high.
- data_in  input  DATA_W  payload word; sampled only on an accepting edge.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block can accept a word; defined as (state==IDLE) && !areset.
- out  output  1  serial bit, registered.
- busy  output  1  high whenever a frame is in flight (state != IDLE), registered.
- done  output  1  one-cycle pulse, high while the last payload bit is on out, registered.

## Operation
- States:
  - IDLE: out=0.
  - SYNC: 4 bits, 1,0,1,0.
  - DATA: DATA_W bits, shift register MSB first.
  - GAP: GAP_CYCLES zeros.
- Accept: valid_in && ready_out at a rising edge. On that edge:
  - data_in loads into the shift register.
  - The bit counter clears.
  - State moves to SYNC.
- valid_in while not ready is ignored. data_in may change freely after acceptance. A word offered while not ready is not latched; the source holds it until acceptance.
- Transitions:
  - SYNC → DATA after the 4th sync bit.
  - DATA → GAP after bit DATA_W-1, or DATA → IDLE if GAP_CYCLES==0.
  - GAP → IDLE after GAP_CYCLES bits.
- Bit counter:
  - Width is the minimum that holds max(4, DATA_W, GAP_CYCLES)-1.
  - Clears on every state change.
  - Never wraps within a state.
- The shift register shifts left by one on each DATA cycle. out takes its MSB.
- Illegal or unused state encodings recover to IDLE with out=0 on the next edge.
- areset asserted at any time, including mid-frame:
  - Immediately: out=0, busy=0, done=0, state=IDLE, counter=0, shift register=0.
  - The partial frame is abandoned, not resumed.
  - ready_out is 0 while areset is high and goes to 1 in the first cycle after release.

## Timing
- Reset values: out=0, busy=0, done=0; ready_out=0 while areset is asserted.
- Accept at edge E:
  - out=1 (first sync bit) in the cycle after E.
  - Sync bits occupy E+1..E+4.
  - Payload MSB is on out during E+5; payload LSB during E+4+DATA_W.
  - done is high exactly during E+4+DATA_W.
  - GAP zeros occupy E+5+DATA_W .. E+4+DATA_W+GAP_CYCLES.
- busy is high from E+1 through the last GAP cycle, or through the last DATA cycle if GAP_CYCLES==0.
- ready_out returns high in the first IDLE cycle.
- Minimum frame period with valid_in held high: 5+DATA_W+GAP_CYCLES cycles (one IDLE accept cycle per frame).
- Simultaneous events:
  - valid_in rising in the same cycle that GAP ends: not accepted until the following IDLE cycle, because ready is still low on that edge.
  - areset release coincident with a clk edge: that edge is ignored.

## Test plan
- Reset then idle: assert areset mid-cycle, release, hold valid_in=0 for 10 cycles → out=0, busy=0, done=0, ready_out=1 throughout.
- Single frame, DATA_W=8, GAP=2, data_in=8'hA5 → out after accept = 1,0,1,0, 1,0,1,0,0,1,0,1, 0,0; done on the 12th bit; ready_out high again on the 15th cycle after accept.
- Back-to-back: valid_in held high with words 8'hFF then 8'h00 → second accept exactly 15 cycles after the first; out = 1010 11111111 00 [idle] 1010 00000000 00.
- Mid-frame reset: accept 8'h3C, assert areset during payload bit 3 → out=0 and busy=0 immediately; after release no leftover bits appear; the next accept of 8'h81 produces a clean 1010 10000001 00.
- GAP_CYCLES=0, DATA_W=1, data_in=1 → out = 1,0,1,0,1; done coincides with the 5th bit; ready_out high on the next cycle.
- Loopback into the 1010 detector with data_in=8'h00, GAP=2 → the detector's out pulses exactly once, on the 4th sync bit, and never during payload or gap.
